// File: rtl/mac_frame_encoder.sv
// Rebuilds a wire-order 802.3 frame (preamble, SFD, DA, SA, TYPE, payload, pad) from a header word and body bytes.
// Build option: define MAC_ENC_FCS_EN to append the CRC-32 FCS; otherwise the frame ends at the last payload/pad byte.
module mac_frame_encoder #(
    parameter int HEADER_DWIDTH = 128,
    parameter int MIN_PAYLOAD   = 46,
    parameter int MAX_PAYLOAD   = 1500,
    parameter int GEN_PREAMBLE  = 1
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic [HEADER_DWIDTH-1:0] h_fifo_dout,
    input  logic                     h_fifo_empty,
    output logic                     h_fifo_rden,
    input  logic [7:0]               b_fifo_dout,
    input  logic                     b_fifo_del,
    input  logic                     b_fifo_empty,
    output logic                     b_fifo_rden,
    output logic [7:0]               o_fifo_din,
    output logic                     o_fifo_wren,
    output logic                     o_fifo_del,
    input  logic                     o_fifo_afull,
    output logic [3:0]               o_port_mask,
    output logic                     busy,
    output logic                     err_oversize
);
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_HLOAD = 4'd1;
    localparam logic [3:0] S_PRE   = 4'd2;
    localparam logic [3:0] S_SFD   = 4'd3;
    localparam logic [3:0] S_HDR   = 4'd4;
    localparam logic [3:0] S_BRD   = 4'd5;
    localparam logic [3:0] S_BWR   = 4'd6;
    localparam logic [3:0] S_PAD   = 4'd7;
    localparam logic [3:0] S_FCS   = 4'd8;
    localparam logic [10:0] MIN_C  = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_C  = 11'(MAX_PAYLOAD);

    logic [3:0]   state_q, state_d;
    logic [3:0]   cnt_q;
    logic         run_q, busy_q, ovs_q;
    logic [3:0]   mask_q;
    logic [111:0] hdr_q;
    logic [10:0]  pay_q;
    logic         wr_s, last_s, hold_s, drop_s, fire_s, pay_inc_s;
    logic         h_rden_s, b_rden_s;
    logic [7:0]   byte_s;
    logic         hdr_unused_s;

    assign hdr_unused_s = ^h_fifo_dout[HEADER_DWIDTH-113:4];

`ifdef MAC_ENC_FCS_EN
    logic [31:0] crc_q;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction
`else
    // Without FCS the last kept byte of an oversize frame is held back so it can carry the del mark.
    logic [7:0] tail_q;
`endif

    // Next-state and per-cycle output byte selection
    always_comb begin
        state_d  = state_q;
        wr_s     = 1'b0;
        last_s   = 1'b0;
        hold_s   = 1'b0;
        drop_s   = 1'b0;
        byte_s   = 8'h00;
        h_rden_s = 1'b0;
        b_rden_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                h_rden_s = run_q && !h_fifo_empty;
                state_d  = h_rden_s ? S_HLOAD : S_IDLE;
            end
            S_HLOAD: state_d = (GEN_PREAMBLE != 0) ? S_PRE : S_HDR;
            S_PRE: begin
                wr_s    = 1'b1;
                byte_s  = 8'h55;
                state_d = (!o_fifo_afull && cnt_q == 4'd6) ? S_SFD : S_PRE;
            end
            S_SFD: begin
                wr_s    = 1'b1;
                byte_s  = 8'hD5;
                state_d = o_fifo_afull ? S_SFD : S_HDR;
            end
            S_HDR: begin
                wr_s    = 1'b1;
                byte_s  = hdr_q[111:104];
                state_d = (!o_fifo_afull && cnt_q == 4'd13) ? S_BRD : S_HDR;
            end
            S_BRD: begin
                b_rden_s = !b_fifo_empty && !o_fifo_afull;
                state_d  = b_rden_s ? S_BWR : S_BRD;
            end
            S_BWR: begin
                if (pay_q >= MAX_C) begin
                    drop_s = 1'b1;
                end
`ifndef MAC_ENC_FCS_EN
                else if (pay_q == MAX_C - 11'd1 && !b_fifo_del) begin
                    hold_s = 1'b1;
                end
`endif
                else begin
                    wr_s   = 1'b1;
                    byte_s = b_fifo_dout;
`ifndef MAC_ENC_FCS_EN
                    last_s = b_fifo_del && (pay_q >= MIN_C - 11'd1);
`endif
                end
                if (wr_s && o_fifo_afull) begin
                    state_d = S_BWR;
                end else if (last_s) begin
                    state_d = S_IDLE;
                end else if (b_fifo_del) begin
                    state_d = S_PAD;
                end else begin
                    state_d = S_BRD;
                end
            end
            S_PAD: begin
                if (pay_q < MIN_C) begin
                    wr_s = 1'b1;
`ifdef MAC_ENC_FCS_EN
                    state_d = (!o_fifo_afull && pay_q == MIN_C - 11'd1) ? S_FCS : S_PAD;
`else
                    last_s  = (pay_q == MIN_C - 11'd1);
                    state_d = (!o_fifo_afull && last_s) ? S_IDLE : S_PAD;
`endif
                end else begin
`ifdef MAC_ENC_FCS_EN
                    state_d = S_FCS;
`else
                    wr_s    = 1'b1;
                    byte_s  = tail_q;
                    last_s  = 1'b1;
                    state_d = o_fifo_afull ? S_PAD : S_IDLE;
`endif
                end
            end
`ifdef MAC_ENC_FCS_EN
            S_FCS: begin
                wr_s    = 1'b1;
                byte_s  = ~crc_q[7:0];
                last_s  = (cnt_q == 4'd3);
                state_d = (!o_fifo_afull && last_s) ? S_IDLE : S_FCS;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign fire_s    = wr_s && !o_fifo_afull;
    assign pay_inc_s = ((fire_s && (state_q == S_BWR || state_q == S_PAD)) || hold_s) && (pay_q < MAX_C);

    assign h_fifo_rden  = h_rden_s;
    assign b_fifo_rden  = b_rden_s;
    assign o_fifo_din   = byte_s;
    assign o_fifo_wren  = fire_s;
    assign o_fifo_del   = fire_s && last_s;
    assign err_oversize = fire_s && last_s && ovs_q;
    assign o_port_mask  = mask_q;
    assign busy         = busy_q;

    // FSM, byte counter, latched header and payload bookkeeping
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            mask_q  <= 4'h0;
            hdr_q   <= 112'd0;
            pay_q   <= 11'd0;
            ovs_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            busy_q  <= (state_d != S_IDLE);
            cnt_q   <= (state_d != state_q) ? 4'd0 : (fire_s ? cnt_q + 4'd1 : cnt_q);
            if (state_q == S_HLOAD) begin
                mask_q <= h_fifo_dout[3:0];
                hdr_q  <= h_fifo_dout[HEADER_DWIDTH-1 -: 112];
                pay_q  <= 11'd0;
                ovs_q  <= 1'b0;
            end else begin
                if (fire_s && state_q == S_HDR) hdr_q <= {hdr_q[103:0], 8'h00};
                if (pay_inc_s) pay_q <= pay_q + 11'd1;
                if (drop_s) ovs_q <= 1'b1;
            end
        end
    end

`ifdef MAC_ENC_FCS_EN
    // Running CRC over DA..pad; shifted out (unchanged) during FCS
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            crc_q <= 32'hFFFF_FFFF;
        end else if (state_q == S_HLOAD) begin
            crc_q <= 32'hFFFF_FFFF;
        end else if (fire_s && state_q == S_FCS) begin
            crc_q <= {8'hFF, crc_q[31:8]};
        end else if (fire_s && (state_q == S_HDR || state_q == S_BWR || state_q == S_PAD)) begin
            crc_q <= crc32_byte(crc_q, byte_s);
        end
    end
`else
    // Capture of the held-back final kept byte
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tail_q <= 8'h00;
        end else if (hold_s) begin
            tail_q <= b_fifo_dout;
        end
    end
`endif

endmodule
